chroma_burst_modulator: RTL and testbench
=========================================

CHROMA_BURST_MODULATOR -- requirements
Module: chroma_burst_modulator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12: width of every signed sample port.
REQ-002 SHALL have parameter BREEZEWAY_LEN, default 45: clocks from the hsync_start sample to the first burst cycle.
REQ-003 SHALL have parameter BURST_LEN, default 187: burst duration in clocks (9 subcarrier cycles at 74.25 MHz).
REQ-004 SHALL have parameter BURST_AMP, default 512: signed burst amplitude in Q1.11.
REQ-005 SHALL have port clk, input, 1 bit: single clock, 74.25 MHz.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have ports sin_val and cos_val, input, signed DATA_WIDTH: subcarrier from the NCO, Q1.11.
REQ-008 SHALL have ports u_in and v_in, input, signed DATA_WIDTH: colour-difference samples, Q1.11.
REQ-009 SHALL have port hsync_start, input, 1 bit: one-clock pulse marking the line start.
REQ-010 SHALL have port active_video, input, 1 bit: the current sample is picture content.
REQ-011 SHALL have port chroma_out, output, signed DATA_WIDTH: modulated chroma or burst.
REQ-012 SHALL have port chroma_valid, output, 1 bit: chroma_out carries burst or picture chroma.
REQ-013 SHALL have port burst_active, output, 1 bit: chroma_out carries burst; aligned with chroma_out.

Function
REQ-014 SHALL implement FSM states IDLE, BREEZEWAY, BURST, WAIT_ACTIVE and ACTIVE.
REQ-015 SHALL move from any state to BREEZEWAY and clear the state counter when hsync_start=1, including mid-BURST and mid-ACTIVE.
REQ-016 SHALL stay in BREEZEWAY for exactly BREEZEWAY_LEN clocks and then enter BURST.
REQ-017 SHALL stay in BURST for exactly BURST_LEN clocks and then enter WAIT_ACTIVE.
REQ-018 SHALL move from WAIT_ACTIVE to ACTIVE on the first cycle with active_video=1.
REQ-019 SHALL remain in ACTIVE until the next hsync_start.
REQ-020 SHALL compute the pre-output as -(sin_val*BURST_AMP)>>>11 in BURST.
REQ-021 SHALL compute the pre-output as ((u_in*sin_val)>>>11)+((v_in*cos_val)>>>11) in ACTIVE when active_video=1.
REQ-022 SHALL use a pre-output of 0 in all other cases.
REQ-023 SHALL keep 2*DATA_WIDTH-bit products, apply arithmetic shifts (floor) and form the sum at DATA_WIDTH+1 bits before the width reduction in REQ-036/REQ-037.
REQ-024 SHALL have a fixed latency of 2 clocks (product register, then sum/limit register) from the inputs to chroma_out.
REQ-025 SHALL delay chroma_valid and burst_active through the same 2 stages so they are cycle-aligned with chroma_out.
REQ-026 SHALL hold chroma_out, chroma_valid and burst_active at 0 in IDLE and BREEZEWAY once the pipeline drains.
REQ-027 SHALL set chroma_valid to 0 for ACTIVE samples with active_video=0.

Reset
REQ-028 SHALL, on rst_n=0, asynchronously force the FSM to IDLE, the counter to 0, and all pipeline registers and outputs to 0.
REQ-029 SHALL take effect immediately when reset is asserted mid-burst or mid-line, with no residual output.
REQ-030 SHALL, after rst_n deasserts, output 0 until a hsync_start is received.

Configuration
REQ-031 SHALL compile output saturation in when macro CHROMA_SATURATE_EN is defined and out when it is not.
REQ-032 SHALL, with CHROMA_SATURATE_EN defined, clamp the DATA_WIDTH+1-bit sum to [-2048, 2047].
REQ-033 SHALL, without CHROMA_SATURATE_EN, truncate the sum to DATA_WIDTH bits (two's-complement wrap).

Structure
REQ-034 SHALL place the FSM state enum, the Q1.11 fraction-bit constant (11) and the default timing constants in shared package chroma_pkg.
REQ-035 SHALL place the multiplies, shifts and sum in sub-module chroma_mac, leaving the FSM, counter and alignment pipeline at top level.
REQ-036 SHALL place the saturate/wrap logic in sub-module chroma_mac.
REQ-037 SHALL guard the saturate/wrap logic in chroma_mac with CHROMA_SATURATE_EN.

Verification
REQ-038 SHALL cover: rst_n=0 with random inputs -> chroma_out=0, chroma_valid=0, burst_active=0 throughout.
REQ-039 SHALL cover: hsync_start pulse at cycle 0, sin_val=2047 -> burst_active=1 on cycles 48..234 only, with chroma_out=-512 during that window.
REQ-040 SHALL cover: ACTIVE with active_video=1, u_in=1024, v_in=0, sin_val=2047 -> chroma_out=1023 and chroma_valid=1 two clocks later.
REQ-041 SHALL cover: u_in=v_in=sin_val=cos_val=2047 -> chroma_out=2047 with CHROMA_SATURATE_EN, -4 without it.
REQ-042 SHALL cover: second hsync_start at cycle 100 of BURST -> burst_active low 2 clocks later, then a full 187-clock burst after a new 45-clock breezeway.
REQ-043 SHALL cover: rst_n pulsed low mid-ACTIVE -> outputs 0 in the same cycle, and 0 until the next hsync_start.

Source files
------------

// File: rtl/chroma_pkg.sv
// Shared types and constants for the chroma burst modulator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package chroma_pkg;

    // Q1.11 sample format: 11 fraction bits.
    localparam int FRAC_BITS         = 11;

    // Default timing and amplitude for 74.25 MHz sampling.
    localparam int DEF_DATA_WIDTH    = 12;
    localparam int DEF_BREEZEWAY_LEN = 45;
    localparam int DEF_BURST_LEN     = 187;
    localparam int DEF_BURST_AMP     = 512;

    // Line sequencer states.
    typedef enum logic [2:0] {
        IDLE,
        BREEZEWAY,
        BURST,
        WAIT_ACTIVE,
        ACTIVE
    } state_t;

    // Operand selection handed to the MAC for the current sample.
    typedef enum logic [1:0] {
        MAC_ZERO,
        MAC_BURST,
        MAC_ACTIVE
    } mac_sel_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/chroma_mac.sv
// Chroma MAC: burst or U/V quadrature modulation, shift, sum, then saturate (CHROMA_SATURATE_EN) or wrap.
// Latency: 2 clocks (product register, then sum/limit register).
// Backpressure: none; accepts one sample per clock unconditionally.
module chroma_mac
    import chroma_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_AMP  = DEF_BURST_AMP
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  mac_sel_t                     sel,
    input  logic signed [DATA_WIDTH-1:0] sin_val,
    input  logic signed [DATA_WIDTH-1:0] cos_val,
    input  logic signed [DATA_WIDTH-1:0] u_in,
    input  logic signed [DATA_WIDTH-1:0] v_in,
    output logic signed [DATA_WIDTH-1:0] chroma_out
);

    localparam int PW = 2 * DATA_WIDTH;
    localparam int SW = DATA_WIDTH + 1;
    localparam logic signed [PW-1:0] AMP_X = PW'(BURST_AMP);
`ifdef CHROMA_SATURATE_EN
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    logic signed [PW-1:0]         sin_x, cos_x, u_x, v_x;
    logic signed [PW-1:0]         prod_a_d, prod_b_d;
    logic signed [PW-1:0]         prod_a_q, prod_b_q;
    logic signed [SW-1:0]         sum;
    logic signed [DATA_WIDTH-1:0] lim;

    // Sign-extend operands to full product width so products are exact.
    assign sin_x = {{DATA_WIDTH{sin_val[DATA_WIDTH-1]}}, sin_val};
    assign cos_x = {{DATA_WIDTH{cos_val[DATA_WIDTH-1]}}, cos_val};
    assign u_x   = {{DATA_WIDTH{u_in[DATA_WIDTH-1]}}, u_in};
    assign v_x   = {{DATA_WIDTH{v_in[DATA_WIDTH-1]}}, v_in};

    // Select products: inverted scaled subcarrier for burst, U*sin and V*cos for picture.
    always_comb begin
        prod_a_d = '0;
        prod_b_d = '0;
        case (sel)
            MAC_BURST: begin
                prod_a_d = -(sin_x * AMP_X);
            end
            MAC_ACTIVE: begin
                prod_a_d = u_x * sin_x;
                prod_b_d = v_x * cos_x;
            end
            default: begin
                prod_a_d = '0;
                prod_b_d = '0;
            end
        endcase
    end

    // Stage 1: product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_a_q <= '0;
            prod_b_q <= '0;
        end else begin
            prod_a_q <= prod_a_d;
            prod_b_q <= prod_b_d;
        end
    end

    // Floor-shift each product back to Q1.11, sum one bit wide, then reduce to sample width.
    always_comb begin
        sum = SW'(prod_a_q >>> FRAC_BITS) + SW'(prod_b_q >>> FRAC_BITS);
        lim = '0;
`ifdef CHROMA_SATURATE_EN
        if (sum > SAT_MAX) begin
            lim = DATA_WIDTH'(SAT_MAX);
        end else if (sum < SAT_MIN) begin
            lim = DATA_WIDTH'(SAT_MIN);
        end else begin
            lim = DATA_WIDTH'(sum);
        end
`else
        lim = DATA_WIDTH'(sum);
`endif
    end

    // Stage 2: sum/limit register drives the output directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chroma_out <= '0;
        end else begin
            chroma_out <= lim;
        end
    end

endmodule

// File: rtl/chroma_burst_modulator.sv
// Colour burst insertion and QAM chroma modulation per video line; saturation optional via CHROMA_SATURATE_EN.
// Latency: 2 clocks from inputs to chroma_out/chroma_valid/burst_active.
// Backpressure: none; streaming at one sample per clock, hsync_start restarts the line at any time.
module chroma_burst_modulator
    import chroma_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int BREEZEWAY_LEN = DEF_BREEZEWAY_LEN,
    parameter int BURST_LEN     = DEF_BURST_LEN,
    parameter int BURST_AMP     = DEF_BURST_AMP
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] sin_val,
    input  logic signed [DATA_WIDTH-1:0] cos_val,
    input  logic signed [DATA_WIDTH-1:0] u_in,
    input  logic signed [DATA_WIDTH-1:0] v_in,
    input  logic                         hsync_start,
    input  logic                         active_video,
    output logic signed [DATA_WIDTH-1:0] chroma_out,
    output logic                         chroma_valid,
    output logic                         burst_active
);

    localparam int CNT_W = $clog2(max_int(BREEZEWAY_LEN, BURST_LEN) + 1);
    localparam logic [CNT_W-1:0] BW_LAST = CNT_W'(BREEZEWAY_LEN - 1);
    localparam logic [CNT_W-1:0] BL_LAST = CNT_W'(BURST_LEN - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    mac_sel_t         sel;
    logic             pre_vld;
    logic             pre_burst;
    logic             vld_p1;
    logic             burst_p1;

    // Line sequencer: hsync_start always restarts the breezeway, overriding any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else if (hsync_start) begin
            state_q <= BREEZEWAY;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                BREEZEWAY: begin
                    if (cnt_q == BW_LAST) begin
                        state_q <= BURST;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BURST: begin
                    if (cnt_q == BL_LAST) begin
                        state_q <= WAIT_ACTIVE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WAIT_ACTIVE: begin
                    if (active_video) begin
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    state_q <= ACTIVE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Decide what the current sample carries; only ACTIVE samples flagged as picture get modulated.
    always_comb begin
        sel = MAC_ZERO;
        if (state_q == BURST) begin
            sel = MAC_BURST;
        end else if ((state_q == ACTIVE) && active_video) begin
            sel = MAC_ACTIVE;
        end
    end

    assign pre_vld   = (sel != MAC_ZERO);
    assign pre_burst = (state_q == BURST);

    // Two-stage flag pipeline matching the MAC so flags line up with chroma_out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            burst_p1     <= 1'b0;
            chroma_valid <= 1'b0;
            burst_active <= 1'b0;
        end else begin
            vld_p1       <= pre_vld;
            burst_p1     <= pre_burst;
            chroma_valid <= vld_p1;
            burst_active <= burst_p1;
        end
    end

    chroma_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_AMP  (BURST_AMP)
    ) u_mac (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel        (sel),
        .sin_val    (sin_val),
        .cos_val    (cos_val),
        .u_in       (u_in),
        .v_in       (v_in),
        .chroma_out (chroma_out)
    );

endmodule

// File: tb/tb_chroma_burst_modulator.sv
// Scoreboard bench for chroma_burst_modulator: expected samples queued at drive time, compared 2 clocks later.
// Latency: expects 2-clock alignment of chroma_out, chroma_valid and burst_active.
// Backpressure: n/a; stimulus is one sample per clock.
module tb_chroma_burst_modulator;

    localparam int DW   = 12;
    localparam int BW   = 45;
    localparam int BL   = 187;
    localparam int AMP  = 512;
    localparam int FRAC = 11;

    typedef struct {
        int out;
        bit vld;
        bit burst;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic signed [DW-1:0] sin_val;
    logic signed [DW-1:0] cos_val;
    logic signed [DW-1:0] u_in;
    logic signed [DW-1:0] v_in;
    logic                 hsync_start;
    logic                 active_video;
    logic signed [DW-1:0] chroma_out;
    logic                 chroma_valid;
    logic                 burst_active;

    exp_t sb[$];
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   hs_cyc;
    int   d;
    bit   act_seen;
    int   b_cnt;
    int   b_first;
    int   b_last;

    chroma_burst_modulator #(
        .DATA_WIDTH    (DW),
        .BREEZEWAY_LEN (BW),
        .BURST_LEN     (BL),
        .BURST_AMP     (AMP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sin_val      (sin_val),
        .cos_val      (cos_val),
        .u_in         (u_in),
        .v_in         (v_in),
        .hsync_start  (hsync_start),
        .active_video (active_video),
        .chroma_out   (chroma_out),
        .chroma_valid (chroma_valid),
        .burst_active (burst_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int rnd();
        return int'($urandom_range(4095)) - 2048;
    endfunction

    function automatic bit rbit();
        return bit'($urandom_range(1));
    endfunction

    // Expected output for a sample driven dd cycles after the last hsync (dd=0: none since reset).
    function automatic exp_t calc(input int dd, input bit seen, input bit av,
                                  input int s, input int c, input int u, input int v);
        exp_t                 e;
        int                   sum;
        int                   t;
        logic signed [12:0]   s13;
        logic signed [DW-1:0] o12;
        e.burst = (dd >= BW + 1) && (dd <= BW + BL);
        e.vld   = e.burst || ((dd > BW + BL) && seen && av);
        sum = 0;
        if (e.burst) begin
            sum = (-(s * AMP)) >>> FRAC;
        end else if (e.vld) begin
            sum = ((u * s) >>> FRAC) + ((v * c) >>> FRAC);
        end
        s13 = 13'(sum);
        t   = s13;
`ifdef CHROMA_SATURATE_EN
        if (t > 2047) begin
            t = 2047;
        end else if (t < -2048) begin
            t = -2048;
        end
        e.out = t;
`else
        o12   = 12'(s13);
        e.out = o12;
`endif
        return e;
    endfunction

    task automatic step(input bit hs, input bit av, input int s, input int c, input int u, input int v);
        exp_t e;
        int   off;
        @(negedge clk);
        cyc++;
        if (sb.size() >= 2) begin
            e = sb.pop_front();
            chk("chroma_out", $signed(chroma_out), e.out);
            chk("chroma_valid", chroma_valid, int'(e.vld));
            chk("burst_active", burst_active, int'(e.burst));
        end
        off = cyc - hs_cyc;
        if ((burst_active === 1'b1) && (off >= 3)) begin
            b_cnt++;
            if (b_first < 0) b_first = off;
            b_last = off;
        end
        hsync_start  = hs;
        active_video = av;
        sin_val      = 12'(s);
        cos_val      = 12'(c);
        u_in         = 12'(u);
        v_in         = 12'(v);
        sb.push_back(calc(d, act_seen, av, s, c, u, v));
        if (hs) begin
            d        = 1;
            act_seen = 1'b0;
            hs_cyc   = cyc;
            b_cnt    = 0;
            b_first  = -1;
            b_last   = -1;
        end else if (d > 0) begin
            if ((d > BW + BL) && av) act_seen = 1'b1;
            if (d < 100000) d++;
        end
    endtask

    task automatic apply_reset(input int n);
        exp_t z;
        @(negedge clk);
        rst_n        = 1'b0;
        hsync_start  = rbit();
        active_video = rbit();
        sin_val      = 12'(rnd());
        cos_val      = 12'(rnd());
        u_in         = 12'(rnd());
        v_in         = 12'(rnd());
        #1;
        chk("rst_out_now", $signed(chroma_out), 0);
        chk("rst_vld_now", chroma_valid, 0);
        chk("rst_burst_now", burst_active, 0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            hsync_start  = rbit();
            active_video = rbit();
            sin_val      = 12'(rnd());
            cos_val      = 12'(rnd());
            u_in         = 12'(rnd());
            v_in         = 12'(rnd());
            #1;
            chk("rst_out", $signed(chroma_out), 0);
            chk("rst_vld", chroma_valid, 0);
            chk("rst_burst", burst_active, 0);
        end
        @(negedge clk);
        hsync_start  = 1'b0;
        active_video = 1'b0;
        sin_val      = '0;
        cos_val      = '0;
        u_in         = '0;
        v_in         = '0;
        rst_n        = 1'b1;
        sb.delete();
        z.out   = 0;
        z.vld   = 1'b0;
        z.burst = 1'b0;
        sb.push_back(z);
        sb.push_back(z);
        d        = 0;
        act_seen = 1'b0;
    endtask

    task automatic line_check(input string tag);
        chk({tag, "_burst_len"}, b_cnt, BL);
        chk({tag, "_burst_first"}, b_first, BW + 3);
        chk({tag, "_burst_last"}, b_last, BW + BL + 2);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        cyc          = 0;
        hs_cyc       = -1000;
        d            = 0;
        act_seen     = 1'b0;
        b_cnt        = 0;
        b_first      = -1;
        b_last       = -1;
        rst_n        = 1'b0;
        hsync_start  = 1'b0;
        active_video = 1'b0;
        sin_val      = '0;
        cos_val      = '0;
        u_in         = '0;
        v_in         = '0;

        // Reset with random inputs, then idle with no hsync must stay silent.
        apply_reset(8);
        repeat (12) step(1'b0, rbit(), rnd(), rnd(), rnd(), rnd());

        // Line A: full-scale sine through the burst window.
        step(1'b1, 1'b0, 2047, 0, 0, 0);
        for (int i = 1; i < 240; i++) step(1'b0, 1'b0, 2047, rnd(), rnd(), rnd());
        line_check("lineA");

        // Picture: U only, then random mix with gaps, then overflow corner.
        repeat (8) step(1'b0, 1'b1, 2047, 0, 1024, 0);
        repeat (30) step(1'b0, rbit(), rnd(), rnd(), rnd(), rnd());
        repeat (6) step(1'b0, 1'b1, 2047, 2047, 2047, 2047);

        // Line B cut short by a fresh hsync at sample 100 of its burst.
        step(1'b1, 1'b0, rnd(), rnd(), rnd(), rnd());
        for (int i = 1; i < BW + 1 + 100; i++) step(1'b0, 1'b0, rnd(), rnd(), rnd(), rnd());

        // Line C: must give a complete breezeway and burst.
        step(1'b1, 1'b0, rnd(), rnd(), rnd(), rnd());
        for (int i = 1; i < 240; i++) step(1'b0, rbit(), rnd(), rnd(), rnd(), rnd());
        line_check("lineC");
        repeat (10) step(1'b0, 1'b1, 2047, 0, 1024, 0);

        // Reset mid-picture, then silence until the next hsync.
        apply_reset(5);
        repeat (20) step(1'b0, rbit(), rnd(), rnd(), rnd(), rnd());

        // Line D: sequencer restarts normally after reset.
        step(1'b1, 1'b0, rnd(), rnd(), rnd(), rnd());
        for (int i = 1; i < 240; i++) step(1'b0, rbit(), rnd(), rnd(), rnd(), rnd());
        line_check("lineD");
        repeat (4) step(1'b0, 1'b0, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
